// File: rtl/movegen_pkg.sv
// Shared definitions for the move generator blocks: piece-stack geometry and drain FSM states.
package movegen_pkg;

    localparam int PIECE_W     = 10;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [1:0] {DR_IDLE, DR_DRAIN, DR_DONE} drain_state_t;

endpackage

// File: rtl/movegen_piece_slot_mux.sv
// Slot read mux over a snapshot of the piece stack; out-of-range selects read as zero.
module movegen_piece_slot_mux #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10,
    parameter int SEL_W = $clog2(DEPTH+1)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] slots,
    input  logic [SEL_W-1:0]            sel,
    output logic [WIDTH-1:0]            data
);

    logic [DEPTH-1:0][WIDTH-1:0] gated;

    // One-hot AND stage per slot, OR-reduced below.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign gated[i] = (sel == SEL_W'(i)) ? slots[i] : '0;
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++) data = data | gated[i];
    end

endmodule

// File: rtl/movegen_piece_stack_drain.sv
// Drains a snapshot of the piece stack top-down onto a valid/ready stream, then pulses done.
module movegen_piece_stack_drain
    import movegen_pkg::*;
#(
    parameter  int DEPTH = STACK_DEPTH,
    parameter  int WIDTH = PIECE_W,
    localparam int CNT_W = $clog2(DEPTH+1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       in_count,
    input  logic [DEPTH*WIDTH-1:0] in_stack,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_index,
    output logic                   out_last,
    output logic                   done
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    drain_state_t                state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] snap;
    logic [CNT_W-1:0]            ptr;
    logic [CNT_W-1:0]            cnt_clamp;
    logic [WIDTH-1:0]            slot_data;
    logic                        load, dec, hs;

    assign cnt_clamp = (in_count > DEPTH_C) ? DEPTH_C : in_count;
    assign hs        = out_valid & out_ready;

    movegen_piece_slot_mux #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .SEL_W (CNT_W)
    ) u_mux (
        .slots (snap),
        .sel   (ptr),
        .data  (slot_data)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        case (state)
            DR_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (cnt_clamp == '0) ? DR_DONE : DR_DRAIN;
                end
            end
            DR_DRAIN: begin
                if (hs) begin
                    if (ptr == '0) state_nxt = DR_DONE;
                    else           dec       = 1'b1;
                end
            end
            DR_DONE: state_nxt = DR_IDLE;
            default: state_nxt = DR_IDLE;
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (abort) begin
            state_nxt = DR_IDLE;
            load      = 1'b0;
            dec       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DR_IDLE;
            snap  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                snap <= in_stack;
                ptr  <= (cnt_clamp == '0) ? '0 : cnt_clamp - CNT_W'(1);
            end else if (dec) begin
                ptr <= ptr - CNT_W'(1);
            end
        end
    end

    // Beat outputs come only from state, snapshot and ptr; never from out_ready.
    assign out_valid = (state == DR_DRAIN);
    assign out_data  = out_valid ? slot_data : '0;
    assign out_index = out_valid ? ptr : '0;
    assign out_last  = out_valid && (ptr == '0);
    assign busy      = (state != DR_IDLE);
    assign done      = (state == DR_DONE);

endmodule

// File: tb/tb_movegen_piece_stack_drain.sv
// Self-checking bench: table of directed drains, hand-written corner sequences, random drains vs a queue model.
module tb_movegen_piece_stack_drain;
    import movegen_pkg::*;

    localparam int DEPTH = STACK_DEPTH;
    localparam int WIDTH = PIECE_W;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst_n, start, abort, out_ready;
    logic [CNT_W-1:0]       in_count;
    logic [DEPTH*WIDTH-1:0] in_stack;
    logic                   busy, out_valid, out_last, done;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       out_index;

    int checks   = 0;
    int failures = 0;

    movegen_piece_stack_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_count  (in_count),
        .in_stack  (in_stack),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int pat;        // 0: slot i = (i+1)*0x11, else random
        int mask;       // bit k-1 set: ready forced low in drain cycle k
        int prob;       // percent chance of ready otherwise
        int spur;       // hold start high throughout the drain
        int exp_beats;
        int exp_cycles;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               idx;
        logic             last;
    } beat_t;

    beat_t q[$];
    vec_t  vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DEPTH*WIDTH-1:0] mk_stack(input int pat);
        logic [DEPTH*WIDTH-1:0] s;
        for (int i = 0; i < DEPTH; i++)
            s[i*WIDTH +: WIDTH] = (pat == 0) ? WIDTH'((i+1)*17) : WIDTH'($urandom);
        return s;
    endfunction

    task automatic chk_quiet(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_busy"},  busy,      0);
        chk({nm, "_done"},  done,      0);
        chk({nm, "_data"},  out_data,  0);
        chk({nm, "_index"}, out_index, 0);
        chk({nm, "_last"},  out_last,  0);
    endtask

    // Model: a drain is the clamped stack read top-down; one pop per handshake, done the cycle after the last.
    task automatic run_drain(input int cnt, input int pat, input int mask, input int prob,
                             input int spur, output int beats, output int cycles);
        logic [DEPTH*WIDTH-1:0] stk;
        beat_t b;
        int m;
        stk = mk_stack(pat);
        m   = (cnt > DEPTH) ? DEPTH : cnt;
        q.delete();
        for (int i = m - 1; i >= 0; i--) begin
            b.data = stk[i*WIDTH +: WIDTH];
            b.idx  = i;
            b.last = (i == 0);
            q.push_back(b);
        end
        in_stack = stk;
        in_count = CNT_W'(cnt);
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_stack = mk_stack(1);
        in_count = CNT_W'($urandom);
        beats    = 0;
        cycles   = -1;
        for (int k = 1; k <= 300; k++) begin
            start     = (spur != 0);
            out_ready = (k <= 32 && mask[k-1]) ? 1'b0 : ($urandom_range(99) < prob);
            if (q.size() > 0) begin
                chk("valid", out_valid, 1);
                chk("data",  out_data,  q[0].data);
                chk("index", out_index, q[0].idx);
                chk("last",  out_last,  q[0].last);
                chk("busy",  busy,      1);
                chk("done_early", done, 0);
                if (out_valid && out_ready) begin
                    beats++;
                    void'(q.pop_front());
                end
            end else begin
                chk("valid_end", out_valid, 0);
                chk("done",      done,      1);
                chk("busy_done", busy,      1);
                cycles = k;
                step();
                start = 1'b0;
                chk("done_pulse", done, 0);
                chk("busy_idle",  busy, 0);
                break;
            end
            step();
        end
        if (cycles < 0) chk("timeout", 0, 1);
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int beats, cycles;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_count = '0; in_stack = '0;

        vecs[0] = '{3,  0, 0,     100, 0, 3,  4};   // basic drain
        vecs[1] = '{2,  1, 'b111, 100, 0, 2,  6};   // backpressure on first beat
        vecs[2] = '{0,  1, 0,     100, 0, 0,  1};   // empty drain
        vecs[3] = '{19, 1, 0,     100, 0, 16, 17};  // clamp
        vecs[4] = '{16, 0, 0,     100, 0, 16, 17};  // full
        vecs[5] = '{1,  1, 0,     100, 0, 1,  2};   // single entry
        vecs[6] = '{4,  1, 'b10,  100, 1, 4,  6};   // start held high mid-drain

        step(); step();
        chk_quiet("in_reset");
        rst_n = 1'b1;
        step();
        chk_quiet("post_reset");

        foreach (vecs[i]) begin
            run_drain(vecs[i].cnt, vecs[i].pat, vecs[i].mask, vecs[i].prob, vecs[i].spur, beats, cycles);
            chk($sformatf("tbl%0d_beats", i),  beats,  vecs[i].exp_beats);
            chk($sformatf("tbl%0d_cycles", i), cycles, vecs[i].exp_cycles);
        end

        // Abort after the second handshake of a 5-entry drain.
        in_stack = mk_stack(1); in_count = 5; out_ready = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        chk("abort_pre_idx", out_index, 2);
        out_ready = 1'b0; abort = 1'b1;
        step(); abort = 1'b0;
        chk_quiet("abort");
        step();
        chk_quiet("abort_after");
        run_drain(2, 1, 0, 100, 0, beats, cycles);
        chk("abort_fresh_beats", beats, 2);

        // Abort and start together in IDLE.
        in_count = 3; start = 1'b1; abort = 1'b1;
        step(); start = 1'b0; abort = 1'b0;
        chk_quiet("abort_start");
        step();
        chk_quiet("abort_start2");

        // Abort during DONE leaves the pulse intact.
        in_count = 0; start = 1'b1;
        step(); start = 1'b0; abort = 1'b1;
        chk("abort_done_pulse", done, 1);
        step(); abort = 1'b0;
        chk_quiet("abort_done");

        // Async reset mid-drain.
        in_stack = mk_stack(1); in_count = 5; start = 1'b1;
        step(); start = 1'b0;
        step();
        chk("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        step(); rst_n = 1'b1;
        step();
        chk_quiet("rst_release");

        // Random drains against the model.
        for (int r = 0; r < 30; r++) begin
            int c;
            c = $urandom_range(DEPTH + 4);
            run_drain(c, 1, $urandom, $urandom_range(100, 30), ($urandom_range(3) == 0), beats, cycles);
            chk("rnd_beats", beats, (c > DEPTH) ? DEPTH : c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
